// File: rtl/ah_write_ctrl.sv
// ah_write_ctrl: Nios-started Avalon write controller streaming 16-bit words.
// Optional running checksum built when AH_WR_CHECKSUM_EN is defined.
module ah_write_ctrl #(
    parameter int ADDR_W = 22,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       write_addr,
    input  logic [31:0]       size,
    input  logic              write_en,
    output logic              wr_busy,
    output logic              wr_done,
    output logic [31:0]       wr_checksum,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              control_fixed_location,
    output logic [ADDR_W-1:0] control_write_base,
    output logic [ADDR_W-1:0] control_write_length,
    output logic              control_go,
    input  logic              control_done,
    output logic              user_write_buffer,
    output logic [DATA_W-1:0] user_buffer_data,
    input  logic              user_buffer_full
);

    typedef enum logic [2:0] {
        IDLE,
        GO,
        STREAM,
        WAIT_DONE,
        DONE
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-2:0]   words_q, words_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [ADDR_W-1:0]   len_q, len_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                seen_q, seen_d;
    logic                push;
`ifdef AH_WR_CHECKSUM_EN
    logic [31:0]         cks_q, cks_d;
`endif

    // High address/size bits and size[0] are dropped on purpose.
    logic unused_bits;
    assign unused_bits = ^{write_addr[31:ADDR_W],
                           size[31:ADDR_W], size[0]};

    // Next-state, datapath updates and handshake decode.
    always_comb begin
        state_d    = state_q;
        words_d    = words_q;
        base_d     = base_q;
        len_d      = len_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        seen_d     = seen_q;
        in_ready   = 1'b0;
        push       = 1'b0;
        control_go = 1'b0;
`ifdef AH_WR_CHECKSUM_EN
        cks_d      = cks_q;
`endif
        unique case (1'b1)
            (state_q == IDLE): begin
                if (write_en) begin
                    base_d  = write_addr[ADDR_W-1:0];
                    len_d   = {size[ADDR_W-1:1], 1'b0};
                    words_d = size[ADDR_W-1:1];
                    busy_d  = 1'b1;
                    seen_d  = 1'b0;
`ifdef AH_WR_CHECKSUM_EN
                    cks_d   = '0;
`endif
                    if (size[ADDR_W-1:1] == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d = GO;
                    end
                end
            end
            (state_q == GO): begin
                control_go = 1'b1;
                if (control_done) seen_d = 1'b1;
                state_d = STREAM;
            end
            (state_q == STREAM): begin
                in_ready = !user_buffer_full && (words_q != '0);
                push     = in_valid && in_ready;
                if (control_done) seen_d = 1'b1;
                if (push) begin
                    words_d = words_q - 1'b1;
`ifdef AH_WR_CHECKSUM_EN
                    cks_d   = cks_q + 32'(in_data);
`endif
                    if (words_q == 1) state_d = WAIT_DONE;
                end
            end
            (state_q == WAIT_DONE): begin
                if (control_done) seen_d = 1'b1;
                if (seen_q || control_done) state_d = DONE;
            end
            (state_q == DONE): begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                seen_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and control registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            words_q <= '0;
            base_q  <= '0;
            len_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            seen_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            words_q <= words_d;
            base_q  <= base_d;
            len_q   <= len_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            seen_q  <= seen_d;
        end
    end

`ifdef AH_WR_CHECKSUM_EN
    // Running sum of accepted words, held after completion.
    always_ff @(posedge clk) begin
        if (reset) begin
            cks_q <= '0;
        end else begin
            cks_q <= cks_d;
        end
    end
    assign wr_checksum = cks_q;
`else
    assign wr_checksum = '0;
`endif

    assign wr_busy                = busy_q;
    assign wr_done                = done_q;
    assign control_fixed_location = 1'b0;
    assign control_write_base     = base_q;
    assign control_write_length   = len_q;
    assign user_write_buffer      = push;
    assign user_buffer_data       = push ? in_data : '0;

endmodule

// File: tb/tb_ah_write_ctrl.sv
// tb_ah_write_ctrl: randomized self-checking bench for ah_write_ctrl.
// Expected pushes, lengths and pulse timing come from a transaction model.
module tb_ah_write_ctrl;

    logic        clk = 0;
    logic        reset = 1;
    logic [31:0] write_addr = 0;
    logic [31:0] size = 0;
    logic        write_en = 0;
    logic        wr_busy, wr_done;
    logic [31:0] wr_checksum;
    logic [15:0] in_data = 0;
    logic        in_valid = 0;
    logic        in_ready;
    logic        control_fixed_location;
    logic [21:0] control_write_base, control_write_length;
    logic        control_go;
    logic        control_done = 0;
    logic        user_write_buffer;
    logic [15:0] user_buffer_data;
    logic        user_buffer_full = 0;

    ah_write_ctrl dut (
        .clk(clk), .reset(reset),
        .write_addr(write_addr), .size(size),
        .write_en(write_en), .wr_busy(wr_busy),
        .wr_done(wr_done), .wr_checksum(wr_checksum),
        .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready),
        .control_fixed_location(control_fixed_location),
        .control_write_base(control_write_base),
        .control_write_length(control_write_length),
        .control_go(control_go),
        .control_done(control_done),
        .user_write_buffer(user_write_buffer),
        .user_buffer_data(user_buffer_data),
        .user_buffer_full(user_buffer_full)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [15:0] push_q[$];
    int          push_cyc[$];
    int go_cnt, go_cyc, done_cnt, done_cyc, busy_cnt;
    int push_full, rdy_full;
    logic [21:0] go_base, go_len;
    logic        busy_at_done;

    always @(negedge clk) begin
        if (user_write_buffer) begin
            push_q.push_back(user_buffer_data);
            push_cyc.push_back(cyc);
            if (user_buffer_full) push_full++;
        end
        if (in_ready && user_buffer_full) rdy_full++;
        if (control_go) begin
            go_cnt++;
            go_cyc  = cyc;
            go_base = control_write_base;
            go_len  = control_write_length;
        end
        if (wr_done) begin
            done_cnt++;
            done_cyc     = cyc;
            busy_at_done = wr_busy;
        end
        if (wr_busy) busy_cnt++;
    end

    logic [15:0] exp_w[$];
    int          t0, n, lastc, dcyc, exp_done;
    logic [31:0] exp_sum;
    logic [21:0] exp_base, exp_len;
    bit          words_ok;

    task automatic mon_clear();
        push_q.delete();
        push_cyc.delete();
        go_cnt = 0; go_cyc = -1;
        done_cnt = 0; done_cyc = -1;
        busy_cnt = 0; push_full = 0; rdy_full = 0;
        go_base = 0; go_len = 0; busy_at_done = 0;
    endtask

    // dmode: 0 done dly cycles after last push, 1 same cycle, 2 early
    task automatic do_xfer(input logic [31:0] addr,
                           input logic [31:0] sz,
                           input int dmode, input int dly,
                           input int fst, input int flen,
                           input bit vrand, input int extra);
        int idx;
        int cur;
        bit fin;
        n = int'(sz[21:1]);
        exp_base = addr[21:0];
        exp_len  = 22'(2 * n);
        exp_w.delete();
        exp_sum = 0;
        for (int i = 0; i < n; i++) begin
            exp_w.push_back(16'($urandom));
            exp_sum += 32'(exp_w[i]);
        end
`ifndef AH_WR_CHECKSUM_EN
        exp_sum = 0;
`endif
        mon_clear();
        @(posedge clk); #1;
        write_addr = addr; size = sz; write_en = 1;
        t0 = cyc;
        idx = 0; lastc = -1; dcyc = -1; fin = 0;
        for (int c = 0; c < 300 && !fin; c++) begin
            @(posedge clk); #1;
            cur = cyc;
            write_en = (extra > 0 && c + 1 == extra);
            if (write_en) write_addr = ~addr;
            control_done = 0;
            user_buffer_full = (fst >= 0 && cur - t0 >= fst &&
                                cur - t0 < fst + flen);
            in_valid = (idx < n) &&
                       (!vrand || $urandom_range(0, 3) != 0);
            in_data = (idx < n) ? exp_w[idx] : 16'($urandom);
            #1;
            if (dmode == 2 && cur == t0 + 2) control_done = 1;
            if (dmode == 1 && in_valid && in_ready && idx == n - 1)
                control_done = 1;
            if (dmode == 0 && lastc >= 0 && cur == lastc + dly)
                control_done = 1;
            if (control_done && dcyc < 0) dcyc = cur;
            @(negedge clk);
            if (in_valid && in_ready) begin
                idx++;
                if (idx == n) lastc = cur;
            end
            if (done_cnt > 0) fin = 1;
        end
        @(posedge clk); #1;
        write_en = 0; in_valid = 0; control_done = 0;
        user_buffer_full = 0; write_addr = addr;
        repeat (4) @(posedge clk);
        @(negedge clk);
        if (n == 0) exp_done = t0 + 2;
        else exp_done = (dcyc + 2 > lastc + 3) ? dcyc + 2 : lastc + 3;
        if (!fin) begin
            total++; bad++;
            $display("FAIL timeout: wr_done never seen sz=%0d", sz);
        end
        words_ok = (push_q.size() == n);
        if (words_ok)
            for (int i = 0; i < n; i++)
                if (push_q[i] !== exp_w[i]) words_ok = 0;
    endtask

    task automatic test_reset();
        reset = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if ({wr_busy, wr_done, control_go, in_ready, user_write_buffer,
             control_fixed_location} !== 6'b0) begin
            bad++;
            $display("FAIL reset_ctl: got %b want 0",
                     {wr_busy, wr_done, control_go, in_ready,
                      user_write_buffer, control_fixed_location});
        end
        total++;
        if ({control_write_base, control_write_length} !== 44'b0) begin
            bad++;
            $display("FAIL reset_bl: got %h/%h want 0",
                     control_write_base, control_write_length);
        end
        total++;
        if (wr_checksum !== 0 || user_buffer_data !== 0) begin
            bad++;
            $display("FAIL reset_data: cks %h data %h want 0",
                     wr_checksum, user_buffer_data);
        end
        @(posedge clk); #1;
        reset = 0;
    endtask

    task automatic test_basic();
        do_xfer(32'h100, 8, 0, 3, -1, 0, 0, 0);
        total++;
        if (go_cnt !== 1 || go_cyc !== t0 + 1) begin
            bad++;
            $display("FAIL basic_go: cnt %0d cyc %0d want 1 %0d",
                     go_cnt, go_cyc, t0 + 1);
        end
        total++;
        if (go_base !== 22'h100 || go_len !== 22'd8) begin
            bad++;
            $display("FAIL basic_bl: got %h/%0d want 100/8",
                     go_base, go_len);
        end
        total++;
        if (!words_ok) begin
            bad++;
            $display("FAIL basic_words: got %0d pushes want 4",
                     push_q.size());
        end
        for (int i = 0; i < push_cyc.size(); i++) begin
            total++;
            if (push_cyc[i] !== t0 + 2 + i) begin
                bad++;
                $display("FAIL basic_pcyc%0d: got %0d want %0d",
                         i, push_cyc[i], t0 + 2 + i);
            end
        end
        total++;
        if (done_cnt !== 1 || done_cyc !== exp_done) begin
            bad++;
            $display("FAIL basic_done: cnt %0d cyc %0d want 1 %0d",
                     done_cnt, done_cyc, exp_done);
        end
        total++;
        if (busy_at_done !== 0 || busy_cnt !== exp_done - t0 - 1) begin
            bad++;
            $display("FAIL basic_busy: at_done %b cnt %0d want 0 %0d",
                     busy_at_done, busy_cnt, exp_done - t0 - 1);
        end
        total++;
        if (wr_checksum !== exp_sum) begin
            bad++;
            $display("FAIL basic_cks: got %h want %h",
                     wr_checksum, exp_sum);
        end
    endtask

    task automatic test_zero_size();
        do_xfer(32'h40, 0, 0, 1, -1, 0, 0, 0);
        total++;
        if (go_cnt !== 0 || push_q.size() !== 0) begin
            bad++;
            $display("FAIL zero_quiet: go %0d push %0d want 0 0",
                     go_cnt, push_q.size());
        end
        total++;
        if (done_cnt !== 1 || done_cyc !== t0 + 2) begin
            bad++;
            $display("FAIL zero_done: cnt %0d cyc %0d want 1 %0d",
                     done_cnt, done_cyc, t0 + 2);
        end
        total++;
        if (wr_checksum !== 0) begin
            bad++;
            $display("FAIL zero_cks: got %h want 0", wr_checksum);
        end
    endtask

    task automatic test_odd_size();
        logic [31:0] a;
        a = $urandom;
        do_xfer(a, 32'hFFC0_0007, 0, 2, -1, 0, 1, 0);
        total++;
        if (go_len !== 22'd6 || go_base !== a[21:0]) begin
            bad++;
            $display("FAIL odd_bl: got %h/%0d want %h/6",
                     go_base, go_len, a[21:0]);
        end
        total++;
        if (!words_ok || push_q.size() !== 3) begin
            bad++;
            $display("FAIL odd_words: got %0d pushes want 3",
                     push_q.size());
        end
        total++;
        if (done_cyc !== exp_done || wr_checksum !== exp_sum) begin
            bad++;
            $display("FAIL odd_done: cyc %0d cks %h want %0d %h",
                     done_cyc, wr_checksum, exp_done, exp_sum);
        end
    endtask

    task automatic test_backpressure();
        do_xfer(32'h800, 6, 0, 1, 3, 5, 0, 0);
        total++;
        if (push_full !== 0 || rdy_full !== 0) begin
            bad++;
            $display("FAIL bp_full: push %0d ready %0d want 0 0",
                     push_full, rdy_full);
        end
        total++;
        if (!words_ok) begin
            bad++;
            $display("FAIL bp_words: got %0d pushes want 3",
                     push_q.size());
        end
        total++;
        if (push_cyc.size() != 3 || push_cyc[1] !== t0 + 8) begin
            bad++;
            $display("FAIL bp_resume: got %0d want %0d",
                     push_cyc.size() > 1 ? push_cyc[1] : -1, t0 + 8);
        end
        total++;
        if (done_cnt !== 1 || done_cyc !== exp_done) begin
            bad++;
            $display("FAIL bp_done: cnt %0d cyc %0d want 1 %0d",
                     done_cnt, done_cyc, exp_done);
        end
    endtask

    task automatic test_done_same();
        do_xfer(32'h1234, 10, 1, 0, -1, 0, 0, 3);
        total++;
        if (done_cnt !== 1 || done_cyc !== lastc + 3) begin
            bad++;
            $display("FAIL same_done: cnt %0d cyc %0d want 1 %0d",
                     done_cnt, done_cyc, lastc + 3);
        end
        total++;
        if (go_cnt !== 1 || go_base !== 22'h1234 || !words_ok) begin
            bad++;
            $display("FAIL same_busy_en: go %0d base %h want 1 1234",
                     go_cnt, go_base);
        end
    endtask

    task automatic test_done_early();
        do_xfer(32'h5000, 12, 2, 0, -1, 0, 1, 1);
        total++;
        if (done_cnt !== 1 || done_cyc !== lastc + 3) begin
            bad++;
            $display("FAIL early_done: cnt %0d cyc %0d want 1 %0d",
                     done_cnt, done_cyc, lastc + 3);
        end
        total++;
        if (go_cnt !== 1 || !words_ok || wr_checksum !== exp_sum) begin
            bad++;
            $display("FAIL early_data: go %0d cks %h want 1 %h",
                     go_cnt, wr_checksum, exp_sum);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 8; k++) begin
            logic [31:0] a, s;
            int m, d, fs;
            a  = $urandom;
            s  = $urandom_range(0, 41);
            m  = $urandom_range(0, 2);
            d  = $urandom_range(1, 5);
            fs = $urandom_range(0, 1) ? int'($urandom_range(2, 10)) : -1;
            do_xfer(a, s, m, d, fs, $urandom_range(1, 6), 1, 0);
            total++;
            if (!words_ok || done_cnt !== 1 ||
                done_cyc !== exp_done) begin
                bad++;
                $display("FAIL rand%0d: n %0d got %0d done %0d@%0d want %0d",
                         k, n, push_q.size(), done_cnt, done_cyc,
                         exp_done);
            end
            total++;
            if (wr_checksum !== exp_sum ||
                (n > 0 && (go_len !== exp_len ||
                           go_base !== exp_base))) begin
                bad++;
                $display("FAIL rand%0d_bl: cks %h len %0d want %h %0d",
                         k, wr_checksum, go_len, exp_sum, exp_len);
            end
        end
    endtask

    task automatic test_mid_reset();
        mon_clear();
        @(posedge clk); #1;
        write_addr = 32'h2000; size = 40; write_en = 1;
        in_valid = 1; in_data = 16'hBEEF;
        @(posedge clk); #1;
        write_en = 0;
        repeat (4) @(posedge clk);
        #1;
        reset = 1;
        @(posedge clk); #1;
        total++;
        if ({wr_busy, wr_done, control_go, in_ready,
             user_write_buffer} !== 5'b0) begin
            bad++;
            $display("FAIL mrst_ctl: got %b want 0",
                     {wr_busy, wr_done, control_go, in_ready,
                      user_write_buffer});
        end
        total++;
        if (control_write_base !== 0 || control_write_length !== 0 ||
            wr_checksum !== 0 || user_buffer_data !== 0) begin
            bad++;
            $display("FAIL mrst_data: %h %h %h %h want 0",
                     control_write_base, control_write_length,
                     wr_checksum, user_buffer_data);
        end
        reset = 0; in_valid = 0;
        do_xfer(32'h3000, 4, 0, 2, -1, 0, 0, 0);
        total++;
        if (go_cnt !== 1 || go_cyc !== t0 + 1 || !words_ok ||
            done_cnt !== 1 || done_cyc !== exp_done ||
            wr_checksum !== exp_sum) begin
            bad++;
            $display("FAIL mrst_restart: go %0d@%0d done %0d@%0d cks %h want %h",
                     go_cnt, go_cyc, done_cnt, done_cyc,
                     wr_checksum, exp_sum);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_size();
        test_odd_size();
        test_backpressure();
        test_done_same();
        test_done_early();
        test_random();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ah_write_ctrl.md
Name: ah_write_ctrl

Overview:
Write-side counterpart of the read controller. It accepts a base address and byte size from the Nios and starts the Avalon write master. It streams 16-bit result words from user logic into the master's write buffer, with back-pressure, and reports completion to the Nios. It sits between the user datapath, the Nios PIO registers and the Avalon write master template.

Parameters:
ADDR_W, 22, width of control_write_base / control_write_length
DATA_W, 16, width of the data word (byte-lane math assumes 16)

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
write_addr  in  32  Nios: byte base address of the destination
size  in  32  Nios: transfer size in bytes
write_en  in  1  Nios: start request, sampled in IDLE only
wr_busy  out  1  high from accepted start until DONE exits
wr_done  out  1  one-cycle pulse when the transfer has fully completed
wr_checksum  out  32  running sum of written words (see Optional Feature)
in_data  in  16  user data word
in_valid  in  1  user: in_data valid
in_ready  out  1  block accepts in_data this cycle
control_fixed_location  out  1  tied 0 (incrementing addresses)
control_write_base  out  22  registered base for the master
control_write_length  out  22  registered length in bytes for the master
control_go  out  1  one-cycle start pulse to the master
control_done  in  1  master: all writes committed
user_write_buffer  out  1  push strobe into the master write FIFO
user_buffer_data  out  16  word pushed into the master write FIFO
user_buffer_full  in  1  master write FIFO full

Behaviour:
- Reset values: all outputs 0; state IDLE; word counter 0; done_seen 0; checksum 0.
- FSM states: IDLE, GO, STREAM, WAIT_DONE, DONE.
- IDLE with write_en=1:
  - Latch base = write_addr[21:0] and len = {size[21:1],1'b0}, i.e. odd sizes round down and only the low 22 bits are used.
  - Load words_left = size[21:1]. Clear checksum. Set wr_busy.
  - If words_left==0: go directly to DONE, with no control_go. Otherwise go to GO.
- GO:
  - control_go=1 for exactly this cycle; control_write_base/length are stable from this cycle until return to IDLE.
  - Next state is STREAM.
- STREAM:
  - in_ready = !user_buffer_full && words_left!=0 (combinational).
  - Transfer occurs when in_valid && in_ready. On a transfer: user_write_buffer=1, user_buffer_data=in_data (same cycle, combinational), words_left decrements, and the checksum accumulates.
  - When the last word transfers, next state is WAIT_DONE.
- done_seen: set on control_done in GO, STREAM or WAIT_DONE.
- WAIT_DONE: when done_seen || control_done, next state is DONE. If the last word transfer and control_done coincide, the block passes through WAIT_DONE for one cycle and then goes to DONE.
- DONE: wr_done=1 for one cycle; wr_busy drops the same cycle; next state is IDLE.
- Outside STREAM: in_ready=0 and user_write_buffer=0.
- write_en while busy is ignored and is not queued.
- Latency: control_go rises 1 cycle after write_en. wr_done rises 2 cycles after the final of (last word transfer, control_done) when done arrives late. If done_seen is already set when the last word transfers, the pulse comes 1 cycle later via WAIT_DONE.
- Reset mid-operation: the FSM returns to IDLE and all outputs go to 0 on the next edge. The Avalon master is not reset by this block; software must reset the system.
- Counters are 21 bits wide; there is no wrap because words_left only decrements while it is non-zero.

Optional Feature:
Macro AH_WR_CHECKSUM_EN.
- Defined: wr_checksum holds a 32-bit wrapping sum of every transferred in_data (zero-extended). It is cleared on accepted start and holds its value after DONE until the next start.
- Undefined: no accumulator is built and wr_checksum is tied to 0.

Test Plan:
1. Reset, then write_addr=0x100, size=8, write_en pulse, in_valid held high, control_done 3 cycles after the 4th push.
   Required: control_go pulse with base=0x100, len=8; 4 pushes on consecutive cycles; wr_done one cycle-pulse; checksum equals the sum of the words (macro on).
2. size=0, write_en pulse.
   Required: no control_go, no pushes; wr_done 2 cycles after write_en.
3. size=7.
   Required: len=6; exactly 3 pushes.
4. size=6, user_buffer_full high for 5 cycles mid-stream.
   Required: in_ready=0 and no push while full; resumes with no loss; 3 words total in order.
5. control_done asserted the same cycle as the last push, and separately control_done arriving early during STREAM.
   Required: each case gives exactly one wr_done; a second write_en while busy is ignored.
6. reset asserted mid-STREAM.
   Required: next cycle all outputs 0 and state IDLE; a new write_en starts cleanly. Repeat with the macro off: wr_checksum stays 0.
